// File: rtl/aes128_key_schedule_seq_pkg.sv
// rtl/aes128_key_schedule_seq_pkg.sv - shared AES constants, state encoding and GF(2^8) helpers
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;
    localparam int KW = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } ks_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and conveniently maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
    endfunction

endpackage

// File: rtl/aes128_key_schedule_seq_if.sv
// rtl/aes128_key_schedule_seq_if.sv - key load handshake and round-key read bus
interface aes128_key_schedule_seq_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_rd_en;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_rd_valid;

    modport master (
        output key_valid, key_in, rk_rd_en, rk_idx,
        input  key_ready, busy, done, rk_out, rk_rd_valid
    );

    modport slave (
        input  key_valid, key_in, rk_rd_en, rk_idx,
        output key_ready, busy, done, rk_out, rk_rd_valid
    );
endinterface

// File: rtl/aes128_key_schedule_seq_subword.sv
// rtl/aes128_key_schedule_seq_subword.sv - four parallel AES S-box lookups on a 32-bit word
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);
    assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                       sbox(word_in[15:8]),  sbox(word_in[7:0])};
endmodule

// File: rtl/aes128_key_schedule_seq.sv
// rtl/aes128_key_schedule_seq.sv - iterative AES-128 key expansion with indexed round-key store
// Optional: AES_KS_EQINV_EN stores rounds 1..9 as InvMixColumns for the equivalent inverse cipher.
module aes128_key_schedule_seq
    import aes_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    aes128_key_schedule_seq_if.slave  bus
);
    ks_state_t      state, state_nxt;
    logic [3:0]     rnd;
    logic [KW-1:0]  rk_mem [0:NR];
    logic [KW-1:0]  prev;
    logic [KW-1:0]  nxt;
    logic [KW-1:0]  store_val;
    logic [31:0]    sub;
    logic [31:0]    w0n, w1n, w2n, w3n;
    logic           accept;

    assign bus.key_ready = (state != EXPAND);
    assign bus.busy      = (state == EXPAND);
    assign bus.done      = (state == READY);
    assign accept        = bus.key_valid && bus.key_ready;

`ifdef AES_KS_EQINV_EN
    // Stored middle rounds are transformed, so the raw chain lives in its own register
    logic [KW-1:0] raw_q;
    assign prev      = raw_q;
    assign store_val = (rnd == 4'(NR)) ? nxt : inv_mix(nxt);

    always_ff @(posedge clk) begin
        if (accept)
            raw_q <= bus.key_in;
        else if (state == EXPAND)
            raw_q <= nxt;
    end
`else
    assign prev      = rk_mem[rnd - 4'd1];
    assign store_val = nxt;
`endif

    aes_subword u_subword (
        .word_in  ({prev[23:0], prev[31:24]}),
        .word_out (sub)
    );

    assign w0n = prev[127:96] ^ sub ^ {rcon(rnd), 24'h0};
    assign w1n = prev[95:64] ^ w0n;
    assign w2n = prev[63:32] ^ w1n;
    assign w3n = prev[31:0]  ^ w2n;
    assign nxt = {w0n, w1n, w2n, w3n};

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, READY: if (accept) state_nxt = EXPAND;
            EXPAND:      if (rnd == 4'(NR)) state_nxt = READY;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rnd <= 4'd0;
        else if (accept)
            rnd <= 4'd1;
        else if (state == EXPAND)
            rnd <= rnd + 4'd1;
    end

    // The store is never cleared; reset only blocks the write so an aborted expansion stops at once
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (accept)
                rk_mem[0] <= bus.key_in;
            else if (state == EXPAND)
                rk_mem[rnd] <= store_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rk_out      <= '0;
            bus.rk_rd_valid <= 1'b0;
        end else if (bus.rk_rd_en && bus.done) begin
            bus.rk_out      <= (bus.rk_idx <= 4'(NR)) ? rk_mem[bus.rk_idx] : '0;
            bus.rk_rd_valid <= 1'b1;
        end else begin
            bus.rk_rd_valid <= 1'b0;
        end
    end
endmodule
